// File: rtl/vga_pkg.sv
// Frame buffer geometry and pixel format shared by the read and write sides.
package vga_pkg;

    localparam int unsigned FB_W      = 160;
    localparam int unsigned FB_H      = 100;
    localparam int unsigned FB_DEPTH  = FB_W * FB_H;
    localparam int unsigned FB_ADDR_W = $clog2(FB_DEPTH);
    localparam int unsigned FB_X_W    = $clog2(FB_W);
    localparam int unsigned FB_Y_W    = $clog2(FB_H);
    localparam int unsigned PIX_W     = 24;
    localparam int unsigned CNT_W     = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/fb_pos_counter.sv
// Raster position tracker: x/y plus a running linear address (addr == y*FB_W + x).
// clr alone returns to (0,0); clr with inc lands on (1,0), i.e. pixel 0 consumed.
module fb_pos_counter
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [FB_X_W-1:0]    o_x,
    output logic [FB_Y_W-1:0]    o_y,
    output logic [FB_ADDR_W-1:0] o_addr,
    output logic                 o_last
);

    logic [FB_X_W-1:0]    r_x;
    logic [FB_Y_W-1:0]    r_y;
    logic [FB_ADDR_W-1:0] r_addr;
    logic                 w_x_end;
    logic                 w_y_end;

    assign w_x_end = (r_x == FB_X_W'(FB_W - 1));
    assign w_y_end = (r_y == FB_Y_W'(FB_H - 1));

    // Position update: clear, restart-after-pixel-0, or advance with line/frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_clr && i_inc) begin
            r_x    <= FB_X_W'(1);
            r_y    <= '0;
            r_addr <= FB_ADDR_W'(1);
        end else if (i_clr) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_inc) begin
            if (w_x_end) begin
                r_x <= '0;
                if (w_y_end) begin
                    r_y    <= '0;
                    r_addr <= '0;
                end else begin
                    r_y    <= r_y + FB_Y_W'(1);
                    r_addr <= r_addr + FB_ADDR_W'(1);
                end
            end else begin
                r_x    <= r_x + FB_X_W'(1);
                r_addr <= r_addr + FB_ADDR_W'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_addr = r_addr;
    assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/frame_writer.sv
// Pixel stream to frame-memory write port with frame sync, resync detection and frame counting.
module frame_writer
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_sof,
    input  logic [PIX_W-1:0]     s_data,
    input  logic                 wr_allow,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]     wr_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_resync,
    output logic [CNT_W-1:0]     frame_cnt
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} fw_state_t;

    fw_state_t            r_state;
    logic                 w_accept;
    logic                 w_clr;
    logic                 w_inc;
    logic                 w_last;
    logic [FB_ADDR_W-1:0] w_addr;
    logic [FB_X_W-1:0]    w_x;
    logic [FB_Y_W-1:0]    w_y;
    logic                 w_unused;

    // Ready is held low in reset and for the single DONE cycle.
    assign s_ready  = rst_n & wr_allow & (r_state != DONE);
    assign w_accept = s_valid & s_ready;

    // x/y are only consumed by the read side; the address alone drives writes here.
    assign w_unused = ^{w_x, w_y};

    // Counter control: sof restarts past pixel 0, last pixel and DONE clear, others advance.
    always_comb begin
        w_clr = 1'b0;
        w_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && s_sof) begin
                    w_clr = 1'b1;
                    w_inc = 1'b1;
                end
            end
            WRITE: begin
                if (w_accept) begin
                    if (s_sof) begin
                        w_clr = 1'b1;
                        w_inc = 1'b1;
                    end else if (w_last) begin
                        w_clr = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            DONE:    w_clr = 1'b1;
            default: w_clr = 1'b1;
        endcase
    end

    fb_pos_counter u_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    // Frame FSM with registered write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_resync <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            err_resync <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && s_sof) begin
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= s_data;
                        busy    <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_accept) begin
                        wr_en   <= 1'b1;
                        wr_data <= s_data;
                        if (s_sof) begin
                            wr_addr    <= '0;
                            err_resync <= 1'b1;
                        end else begin
                            wr_addr <= w_addr;
                            if (w_last) begin
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + CNT_W'(1);
                                r_state    <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: full frames, row wrap, pre-sof drop, resync, stalls, reset.
module tb_frame_writer;
    import vga_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_sof;
    logic [PIX_W-1:0]     s_data;
    logic                 wr_allow;
    logic                 wr_en;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]     wr_data;
    logic                 busy;
    logic                 frame_done;
    logic                 err_resync;
    logic [CNT_W-1:0]     frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_resync = 0;
    int seq      = 0;

    frame_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sof      (s_sof),
        .s_data     (s_data),
        .wr_allow   (wr_allow),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .err_resync (err_resync),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) n_done++;
            if (err_resync) n_resync++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [PIX_W-1:0] pix(input int i);
        return {8'(i), 8'(i >> 8), 8'(i ^ 32'h5a)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        check({tag, "_wr_data"},    32'(wr_data),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_err_resync"}, 32'(err_resync), 32'd0);
        check({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
        check({tag, "_s_ready"},    32'(s_ready),    32'd0);
    endtask

    // One beat, optionally preceded by idle cycles; checks the write one cycle later.
    task automatic beat(input logic sof, input int exp_addr, input int gap);
        logic [PIX_W-1:0] d;
        int g;
        for (int k = 0; k < gap; k++) begin
            s_valid = 1'b0;
            tick();
            check("gap_wr_en", 32'(wr_en), 32'd0);
        end
        d       = pix(seq);
        seq++;
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        #1;
        g = 0;
        while (!s_ready && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) check("ready_timeout", 32'(s_ready), 32'd1);
        tick();
        check($sformatf("wr_en@%0d", exp_addr),   32'(wr_en),   32'd1);
        check($sformatf("wr_addr@%0d", exp_addr), 32'(wr_addr), 32'(exp_addr));
        check($sformatf("wr_data@%0d", exp_addr), 32'(wr_data), 32'(d));
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_sof    = 1'b0;
        s_data   = '0;
        wr_allow = 1'b1;
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(s_ready), 32'd1);
        check("post_reset_busy",  32'(busy),    32'd0);

        // Test 1/2: full frame, row wrap, DONE cycle.
        beat(1'b1, 0, 0);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 1; i < FB_DEPTH - 1; i++) beat(1'b0, i, 0);
        check("t1_done_before_last", 32'(n_done), 32'd0);
        beat(1'b0, FB_DEPTH - 1, 0);
        check("t1_frame_done", 32'(frame_done), 32'd1);
        check("t1_frame_cnt",  32'(frame_cnt),  32'd1);
        check("t1_busy_done",  32'(busy),       32'd0);
        check("t2_ready_done", 32'(s_ready),    32'd0);
        tick();
        check("t2_ready_after", 32'(s_ready),    32'd1);
        check("t1_done_pulse",  32'(frame_done), 32'd0);
        check("t1_wr_en_idle",  32'(wr_en),      32'd0);
        check("t1_done_count",  32'(n_done),     32'd1);

        // Test 3: beats without sof in IDLE are dropped.
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_sof   = 1'b0;
            s_data  = pix(1000 + i);
            tick();
            check("t3_drop_wr_en", 32'(wr_en), 32'd0);
            check("t3_drop_busy",  32'(busy),  32'd0);
        end
        s_valid = 1'b0;

        // Test 4: resync at beat 500, frame then needs a full 16000 beats.
        beat(1'b1, 0, 0);
        for (int i = 1; i < 500; i++) beat(1'b0, i, 0);
        beat(1'b1, 0, 0);
        check("t4_err_resync", 32'(err_resync), 32'd1);
        check("t4_busy",       32'(busy),       32'd1);
        tick();
        check("t4_resync_pulse", 32'(err_resync), 32'd0);
        for (int i = 1; i < FB_DEPTH - 1; i++) beat(1'b0, i, 0);
        check("t4_no_early_done", 32'(n_done), 32'd1);
        beat(1'b0, FB_DEPTH - 1, 0);
        check("t4_frame_done",   32'(frame_done), 32'd1);
        check("t4_frame_cnt",    32'(frame_cnt),  32'd2);
        check("t4_resync_count", 32'(n_resync),   32'd1);
        tick();

        // Test 5: random gaps plus a 50-cycle wr_allow hold, from a fresh reset.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        tick();
        rst_n = 1'b1;
        tick();
        beat(1'b1, 0, 0);
        for (int i = 1; i < 7000; i++) beat(1'b0, i, ($urandom_range(0, 7) == 0) ? 1 : 0);
        wr_allow = 1'b0;
        s_valid  = 1'b1;
        s_data   = pix(seq);
        for (int k = 0; k < 50; k++) begin
            #1;
            check("t5_hold_ready", 32'(s_ready), 32'd0);
            tick();
            check("t5_hold_wr_en", 32'(wr_en), 32'd0);
        end
        check("t5_hold_busy", 32'(busy), 32'd1);
        wr_allow = 1'b1;
        s_valid  = 1'b0;
        for (int i = 7000; i < FB_DEPTH; i++) beat(1'b0, i, ($urandom_range(0, 7) == 0) ? 1 : 0);
        check("t5_frame_done",   32'(frame_done), 32'd1);
        check("t5_frame_cnt",    32'(frame_cnt),  32'd1);
        check("t5_resync_count", 32'(n_resync),   32'd1);
        tick();

        // Test 6: reset at beat 8000 abandons the frame.
        beat(1'b1, 0, 0);
        for (int i = 1; i < 8000; i++) beat(1'b0, i, 0);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        tick();
        tick();
        check_reset_outputs("t6_rst_hold");
        s_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        check("t6_done_count", 32'(n_done),    32'd3);
        check("t6_frame_cnt0", 32'(frame_cnt), 32'd0);
        beat(1'b1, 0, 0);
        for (int i = 1; i < FB_DEPTH - 1; i++) beat(1'b0, i, 0);
        check("t6_frame_cnt_pre", 32'(frame_cnt), 32'd0);
        beat(1'b0, FB_DEPTH - 1, 0);
        check("t6_frame_done", 32'(frame_done), 32'd1);
        check("t6_frame_cnt",  32'(frame_cnt),  32'd1);
        tick();
        check("t6_done_total", 32'(n_done), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
